param_sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO; next generation of the team's FIFO under FIFO_IF-based verification.

---
 rtl/param_sync_fifo.sv | 107 ++++++++++
 tb/tb_param_sync_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with FWFT option, flush, count and high-water mark
module param_sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 2,
    parameter int FWFT       = 0,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      hwm
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_next;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CNT_W'(AF_TH)) && !full;
    assign almostempty = !empty && (count_q <= CNT_W'(AE_TH));
    assign count       = count_q;

    // No pass-through: a full FIFO refuses writes and an empty one refuses reads even when both are requested.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        count_next = count_q;
        if (wr_ok && !rd_ok) begin
            count_next = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            hwm       <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count_q   <= count_next;
            wr_ack    <= wr_ok;
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && !rd_ok;
            hwm       <= (count_next > hwm) ? count_next : hwm;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;

            // Flush leaves the last read word visible; only rst clears it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (!flush && rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo, standard and FWFT instances side by side
module tb_param_sync_fifo;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;

    logic [W-1:0]  dout0, dout1;
    logic          ack0, ack1, ovf0, ovf1, udf0, udf1;
    logic          full0, full1, empty0, empty1, af0, af1, ae0, ae1;
    logic [CW-1:0] cnt0, cnt1, hwm0, hwm1;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Reference model: plain queue plus the registered side outputs
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout0 = '0;
    logic         m_ack = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    int           m_hwm = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_TH(AF), .AE_TH(AE), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout0), .wr_ack(ack0), .overflow(ovf0), .underflow(udf0),
        .full(full0), .empty(empty0), .almostfull(af0), .almostempty(ae0),
        .count(cnt0), .hwm(hwm0)
    );

    param_sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_TH(AF), .AE_TH(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout1), .wr_ack(ack1), .overflow(ovf1), .underflow(udf1),
        .full(full1), .empty(empty1), .almostfull(af1), .almostempty(ae1),
        .count(cnt1), .hwm(hwm1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit wok, rok;
        if (rst) begin
            q.delete();
            m_dout0 = '0;
            m_ack = 0; m_ovf = 0; m_udf = 0; m_hwm = 0;
        end else if (flush) begin
            q.delete();
            m_ack = 0; m_ovf = 0; m_udf = 0; m_hwm = 0;
        end else begin
            wok = wr_en && (q.size() < D);
            rok = rd_en && (q.size() > 0);
            if (rok) m_dout0 = q.pop_front();
            if (wok) q.push_back(data_in);
            m_ack = wok;
            m_ovf = wr_en && !wok;
            m_udf = rd_en && !rok;
            if (q.size() > m_hwm) m_hwm = q.size();
        end
    endtask

    task automatic cyc(input bit r, input bit f, input bit w, input bit rd, input logic [W-1:0] d);
        rst = r; flush = f; wr_en = w; rd_en = rd; data_in = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int sz;
            sz = q.size();
            chk("count_std",  32'(cnt0), 32'(sz));
            chk("count_fwft", 32'(cnt1), 32'(sz));
            chk("full_std",   32'(full0),  32'(sz == D));
            chk("full_fwft",  32'(full1),  32'(sz == D));
            chk("empty_std",  32'(empty0), 32'(sz == 0));
            chk("empty_fwft", 32'(empty1), 32'(sz == 0));
            chk("af_std",     32'(af0), 32'(sz >= AF && sz < D));
            chk("af_fwft",    32'(af1), 32'(sz >= AF && sz < D));
            chk("ae_std",     32'(ae0), 32'(sz > 0 && sz <= AE));
            chk("ae_fwft",    32'(ae1), 32'(sz > 0 && sz <= AE));
            chk("wr_ack",     32'({ack0, ack1}), 32'({m_ack, m_ack}));
            chk("overflow",   32'({ovf0, ovf1}), 32'({m_ovf, m_ovf}));
            chk("underflow",  32'({udf0, udf1}), 32'({m_udf, m_udf}));
            chk("hwm_std",    32'(hwm0), 32'(m_hwm));
            chk("hwm_fwft",   32'(hwm1), 32'(m_hwm));
            chk("dout_std",   32'(dout0), 32'(m_dout0));
            chk("dout_fwft",  32'(dout1), (sz > 0) ? 32'(q[0]) : 32'h0);
        end
    end

    initial begin
        // Reset with both requests high; they must be ignored
        cyc(1, 0, 1, 1, 16'h1234);
        check_en = 1'b1;
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_dout",  32'({dout0, dout1}), 0);
        chk("rst_flags", 32'({ack0, ovf0, udf0}), 0);
        chk("rst_hwm",   32'(hwm0), 0);

        // Fill 1..8, then one write too many
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 0, W'(i));
            chk("fill_af", 32'(af0), 32'(i == 6 || i == 7));
            chk("fill_ack", 32'(ack0), 1);
        end
        chk("fill_full", 32'(full0), 1);
        cyc(0, 0, 1, 0, 16'h0009);
        chk("ovf_flag", 32'(ovf0), 1);
        chk("ovf_count", 32'(cnt0), 8);
        chk("ovf_hwm", 32'(hwm0), 8);

        // Drain in order; ninth read underflows and holds the last word
        for (int i = 1; i <= 8; i++) begin
            chk("fwft_head", 32'(dout1), 32'(i));
            cyc(0, 0, 0, 1, '0);
            chk("drain_dout", 32'(dout0), 32'(i));
        end
        cyc(0, 0, 0, 1, '0);
        chk("udf_flag", 32'(udf0), 1);
        chk("udf_hold", 32'(dout0), 32'h8);
        chk("udf_fwft_zero", 32'(dout1), 0);

        // Steady state at count 3 with simultaneous read/write, pointers wrap
        cyc(0, 0, 1, 0, 16'h0011);
        cyc(0, 0, 1, 0, 16'h0022);
        cyc(0, 0, 1, 0, 16'h0033);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 1, 16'hBEEF);
            if (i == 0) chk("rw_first", 32'(dout0), 32'h11);
            if (i == 2) chk("rw_third", 32'(dout0), 32'h33);
            chk("rw_count", 32'(cnt0), 3);
        end
        chk("rw_last", 32'(dout0), 32'hBEEF);

        // Flush keeps data_out on the standard instance
        cyc(0, 1, 0, 0, '0);
        chk("flush_hold", 32'(dout0), 32'hBEEF);
        chk("flush_empty", 32'(empty0), 1);

        // FWFT: a word written to an empty FIFO appears without a read
        cyc(0, 0, 1, 0, 16'hA5A5);
        chk("fwft_show", 32'(dout1), 32'hA5A5);
        cyc(0, 0, 0, 1, '0);
        chk("fwft_pop_empty", 32'(empty1), 1);
        chk("fwft_pop_zero", 32'(dout1), 0);

        // Fill to 5, flush with a write pending, refill past almostempty
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, W'(16'h0100 + i));
        chk("hwm5", 32'(hwm0), 5);
        cyc(0, 1, 1, 0, 16'hDEAD);
        chk("flush_count", 32'(cnt0), 0);
        chk("flush_hwm", 32'(hwm0), 0);
        chk("flush_ack", 32'(ack0), 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 0, W'(16'h0200 + i));
            chk("refill_ae", 32'(ae0), 32'(i <= 2));
        end

        // Empty with both requests: only the write lands
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 1, 1, 16'h7777);
        chk("empty_rw_udf", 32'(udf0), 1);
        chk("empty_rw_count", 32'(cnt0), 1);
        chk("empty_rw_fwft", 32'(dout1), 32'h7777);

        // Full with both requests: only the read lands
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, W'(16'h0300 + i));
        cyc(0, 0, 1, 1, 16'h9999);
        chk("full_rw_ovf", 32'(ovf0), 1);
        chk("full_rw_count", 32'(cnt0), 7);
        chk("full_rw_dout", 32'(dout0), 32'h7777);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
